// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer.
// The main entry drives the MEM-side outputs. The skid entry catches the single
// instruction accepted in the cycle in which MEM applies backpressure.
// Because in_ready comes straight from a flop, out_ready never reaches the EX side
// combinationally.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1 on that side. A producer holding valid=1 keeps its fields stable until
// the transfer. While out_valid=1 the stage keeps all outputs stable until
// out_ready=1.
module ex_mem_skid_reg #(
  parameter int DATA_W = 16,
  parameter int CREG_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mwe_i,
  input  logic              mux_i,
  input  logic              rwe_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [CREG_W-1:0] c_reg_i,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              mwe_o,
  output logic              mux_o,
  output logic              rwe_o,
  output logic [DATA_W-1:0] res_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [CREG_W-1:0] c_reg_o,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid, skid_valid, in_ready_q;
  logic              main_mwe, main_mux, main_rwe;
  logic [DATA_W-1:0] main_res, main_data_b;
  logic [CREG_W-1:0] main_creg;
  logic              skid_mwe, skid_mux, skid_rwe;
  logic [DATA_W-1:0] skid_res, skid_data_b;
  logic [CREG_W-1:0] skid_creg;

  logic in_xfer, out_xfer, refill, load_main_in, load_main_skid, load_skid;

  // Handshake decode: main is refilled whenever it is empty or drains this edge.
  // While skid is full, in_ready is 0. A refill therefore takes skid or the
  // input, never both.
  always_comb begin
    in_xfer        = in_valid & in_ready_q;
    out_xfer       = main_valid & out_ready;
    refill         = ~main_valid | out_xfer;
    load_main_skid = refill & skid_valid;
    load_main_in   = refill & ~skid_valid & in_xfer;
    load_skid      = ~refill & in_xfer;
  end

  // Valid bits. Flush overrides everything. in_ready_q tracks ~skid_valid as its own flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (refill) begin
        main_valid <= skid_valid | in_xfer;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (load_skid) begin
        skid_valid <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end
  end

  // Data fields. Flush does not touch them; only the valid bits above clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {main_mwe, main_mux, main_rwe} <= 3'b000;
      main_res    <= '0;
      main_data_b <= '0;
      main_creg   <= '0;
      {skid_mwe, skid_mux, skid_rwe} <= 3'b000;
      skid_res    <= '0;
      skid_data_b <= '0;
      skid_creg   <= '0;
    end else if (!flush) begin
      if (load_main_skid) begin
        {main_mwe, main_mux, main_rwe} <= {skid_mwe, skid_mux, skid_rwe};
        main_res    <= skid_res;
        main_data_b <= skid_data_b;
        main_creg   <= skid_creg;
      end else if (load_main_in) begin
        {main_mwe, main_mux, main_rwe} <= {mwe_i, mux_i, rwe_i};
        main_res    <= res_i;
        main_data_b <= data_b_i;
        main_creg   <= c_reg_i;
      end
      if (load_skid) begin
        {skid_mwe, skid_mux, skid_rwe} <= {mwe_i, mux_i, rwe_i};
        skid_res    <= res_i;
        skid_data_b <= data_b_i;
        skid_creg   <= c_reg_i;
      end
    end
  end

  // Saturating count of edges where MEM holds off a valid instruction; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Output mapping: the write enables are gated so that a bubble never writes.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = main_valid;
    mwe_o     = main_mwe & main_valid;
    rwe_o     = main_rwe & main_valid;
    mux_o     = main_mux;
    res_o     = main_res;
    data_b_o  = main_data_b;
    c_reg_o   = main_creg;
  end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed and model-checked bench for ex_mem_skid_reg.
module tb_ex_mem_skid_reg;

  logic        clk, rst_n;
  logic        in_valid, in_ready, mwe_i, mux_i, rwe_i, flush, out_ready, out_valid;
  logic        mwe_o, mux_o, rwe_o;
  logic [15:0] res_i, data_b_i, res_o, data_b_o, stall_cnt;
  logic [7:0]  c_reg_i, c_reg_o;

  // Second instance with a narrow counter for the saturation check
  logic        s_in_valid, s_in_ready, s_out_ready, s_out_valid, s_mwe_o, s_mux_o, s_rwe_o;
  logic [15:0] s_res_o, s_data_b_o;
  logic [7:0]  s_c_reg_o;
  logic [3:0]  s_stall_cnt;

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q[$];
  logic [15:0] exp_stall;
  logic [15:0] next_id;
  logic        m_in_x, m_out_x;

  ex_mem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mwe_i(mwe_i), .mux_i(mux_i), .rwe_i(rwe_i), .res_i(res_i), .data_b_i(data_b_i),
    .c_reg_i(c_reg_i), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .mwe_o(mwe_o), .mux_o(mux_o), .rwe_o(rwe_o), .res_o(res_o), .data_b_o(data_b_o),
    .c_reg_o(c_reg_o), .stall_cnt(stall_cnt)
  );

  ex_mem_skid_reg #(.DATA_W(16), .CREG_W(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .mwe_i(1'b0), .mux_i(1'b0), .rwe_i(1'b1), .res_i(16'h00aa), .data_b_i(16'h0000),
    .c_reg_i(8'h00), .flush(1'b0), .out_ready(s_out_ready), .out_valid(s_out_valid),
    .mwe_o(s_mwe_o), .mux_o(s_mux_o), .rwe_o(s_rwe_o), .res_o(s_res_o), .data_b_o(s_data_b_o),
    .c_reg_o(s_c_reg_o), .stall_cnt(s_stall_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; the caller then checks outputs and drives inputs 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mwe_i = 1'b0; mux_i = 1'b0; rwe_i = 1'b0;
    res_i = '0; data_b_i = '0; c_reg_i = '0; flush = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    #12;
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_res_o",     32'(res_o),     32'd0);
    chk("rst_rwe_o",     32'(rwe_o),     32'd0);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pass
    in_valid = 1'b1; res_i = 16'h1234; c_reg_i = 8'h05; rwe_i = 1'b1; out_ready = 1'b1;
    tick();
    chk("sp_out_valid", 32'(out_valid), 32'd1);
    chk("sp_res_o",     32'(res_o),     32'h1234);
    chk("sp_c_reg_o",   32'(c_reg_o),   32'h05);
    chk("sp_rwe_o",     32'(rwe_o),     32'd1);
    chk("sp_mwe_o",     32'(mwe_o),     32'd0);
    in_valid = 1'b0;
    tick();
    chk("sp_drained", 32'(out_valid), 32'd0);
    chk("sp_bubble_rwe", 32'(rwe_o), 32'd0);

    // Backpressure: A=1, B=2, C=3
    in_valid = 1'b1; res_i = 16'd1; out_ready = 1'b1;
    tick();
    chk("bp_a_main", 32'(res_o), 32'd1);
    res_i = 16'd2; out_ready = 1'b0;
    tick();
    chk("bp_hold_a1", 32'(res_o), 32'd1);
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    chk("bp_stall1", 32'(stall_cnt), 32'd1);
    res_i = 16'd3;
    tick();
    chk("bp_hold_a2", 32'(res_o), 32'd1);
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    chk("bp_c_blocked", 32'(in_ready), 32'd0);
    chk("bp_stall2", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", 32'(res_o), 32'd2);
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out_c", 32'(res_o), 32'd3);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_stall_final", 32'(stall_cnt), 32'd2);

    // Flush with main and skid full
    mwe_i = 1'b1; rwe_i = 1'b1; in_valid = 1'b1; res_i = 16'h00a0; out_ready = 1'b0;
    tick();
    res_i = 16'h00b0;
    tick();
    chk("fl_full_in_ready", 32'(in_ready), 32'd0);
    chk("fl_full_mwe", 32'(mwe_o), 32'd1);
    flush = 1'b1; res_i = 16'h00c0;
    tick();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_mwe_o", 32'(mwe_o), 32'd0);
    chk("fl_rwe_o", 32'(rwe_o), 32'd0);
    chk("fl_stall_kept", 32'(stall_cnt), 32'd4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_no_skid_leak", 32'(out_valid), 32'd0);
    // Flush with an in-transfer and an out-transfer in the same cycle
    in_valid = 1'b1; res_i = 16'h00d0;
    tick();
    flush = 1'b1; res_i = 16'h00e0;
    tick();
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
    chk("fl2_data_kept", 32'(res_o), 32'h00d0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl2_no_leak", 32'(out_valid), 32'd0);

    // Async reset between edges
    in_valid = 1'b1; res_i = 16'h0055; out_ready = 1'b0;
    tick();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_res_o", 32'(res_o), 32'd0);
    chk("ar_rwe_o", 32'(rwe_o), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after_valid", 32'(out_valid), 32'd0);

    // Saturation on the 4-bit counter instance
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", 32'(s_stall_cnt), 32'd10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_full", 32'(s_stall_cnt), 32'd15);
    chk("sat_held_valid", 32'(s_out_valid), 32'd1);
    tick();
    chk("sat_stays", 32'(s_stall_cnt), 32'd15);

    // Random valid/ready against a reference FIFO model of the two entries
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    exp_q.delete();
    exp_stall = '0;
    next_id = 16'h0100;
    mwe_i = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = (cyc % 1000 < 100) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      rwe_i = 1'($urandom_range(0, 1));
      res_i = next_id;
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("rnd_stall", 32'(stall_cnt), 32'(exp_stall));
      if (exp_q.size() > 0) begin
        chk("rnd_res_o", 32'(res_o), 32'(exp_q[0][15:0]));
        chk("rnd_rwe_o", 32'(rwe_o), 32'(exp_q[0][16]));
      end else begin
        chk("rnd_bubble_rwe", 32'(rwe_o), 32'd0);
      end
      m_out_x = (exp_q.size() > 0) && out_ready;
      m_in_x  = in_valid && (exp_q.size() < 2);
      if ((exp_q.size() > 0) && !out_ready) exp_stall = exp_stall + 16'd1;
      tick();
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_out_x) void'(exp_q.pop_front());
        if (m_in_x) exp_q.push_back({rwe_i, res_i});
      end
      if (m_in_x) next_id = next_id + 16'd1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 SHALL provide parameter DATA_W, 16, width of the result and store-data fields.
REQ-002 SHALL provide parameter CREG_W, 8, width of the destination/condition register field.
REQ-003 SHALL provide parameter CNT_W, 16, width of the stall-cycle counter.
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL provide port in_valid  input  1  EX stage presents a valid instruction.
REQ-007 SHALL provide port in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 SHALL provide ports mwe_i, mux_i, rwe_i  input  1 each  memory-write enable, writeback mux select, register-write enable.
REQ-009 SHALL provide ports res_i, data_b_i  input  DATA_W each  ALU result and store data.
REQ-010 SHALL provide port c_reg_i  input  CREG_W  destination/condition register field.
REQ-011 SHALL provide port flush  input  1  kill all held instructions.
REQ-012 SHALL provide port out_ready  input  1  MEM stage accepts this cycle (replaces legacy stall; stall == ~out_ready).
REQ-013 SHALL provide port out_valid  output  1  MEM stage receives a valid instruction.
REQ-014 SHALL provide ports mwe_o, mux_o, rwe_o, res_o, data_b_o, c_reg_o  output  widths as inputs  registered instruction fields.
REQ-015 SHALL provide port stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL hold two entries: main register (drives outputs) and skid register; each with its own valid bit.
REQ-017 SHALL define in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
REQ-018 SHALL drive in_ready = ~skid_valid, directly from a flop, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = main_valid.
REQ-020 SHALL gate mwe_o and rwe_o with main_valid, so a bubble never writes memory or registers; mux_o, res_o, data_b_o and c_reg_o are unconstrained when out_valid=0.
REQ-021 SHALL have a latency of 1 cycle, in-transfer at edge N to out_valid at N+1, when the stage is empty.
REQ-022 SHALL sustain a throughput of 1 instruction per cycle while out_ready=1.
REQ-023 SHALL refill main on each edge where main is empty or an out-transfer occurs: from skid if skid_valid (skid then empties), else from the input if in-transfer, else main_valid=0.
REQ-024 SHALL capture the input into skid, setting skid_valid=1, on an in-transfer while main is full and no out-transfer occurs.
REQ-025 SHALL preserve order: output order equals input order; no instruction is dropped or duplicated.
REQ-026 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on flush, clear main_valid and skid_valid at the next edge and discard any concurrent in-transfer; flush overrides all other events.
REQ-028 SHALL treat an out-transfer in the flush cycle as completed, with flush then clearing the stage.
REQ-029 SHALL leave data field registers unchanged by flush; only the valid bits clear.
REQ-030 SHALL increment stall_cnt by 1 on each edge where out_valid=1 and out_ready=0, saturating at 2^CNT_W-1; it is not cleared by flush.
REQ-031 SHALL handle in_valid=0 with out_ready=1 by draining the held entries, one per cycle.

Reset
REQ-032 SHALL, while rst_n=0, immediately force main_valid=0, skid_valid=0, all output fields=0, stall_cnt=0, in_ready=1.
REQ-033 SHALL resume on the first rising clk edge after rst_n deasserts; reset mid-operation discards both entries.

Verification
REQ-034 SHALL be verified for single pass: rst_n release, in_valid=1 with res_i=16'h1234, c_reg_i=8'h05, rwe_i=1, out_ready=1 -> next cycle out_valid=1, res_o=16'h1234, c_reg_o=8'h05, rwe_o=1.
REQ-035 SHALL be verified for backpressure: stream A=1, B=2, C=3 with out_ready=0 from cycle 2 -> A held on outputs, B in skid, in_ready=0, C not accepted; out_ready=1 -> outputs A, B, C on consecutive cycles; stall_cnt equals the stalled cycles.
REQ-036 SHALL be verified for flush: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, mwe_o=0, rwe_o=0; no later output of the flushed or concurrent data.
REQ-037 SHALL be verified for async reset: rst_n=0 mid-stream, between clk edges -> outputs 0 and in_ready=1 before the next edge.
REQ-038 SHALL be verified for saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and held.
REQ-039 SHALL be verified for random valid/ready: 10k cycles against a reference FIFO model -> order preserved, no loss or duplication, throughput 1/cycle when out_ready is held at 1.
